// File: rtl/bp_fe_bp_two_level_cfg.sv
// Two-level local-history branch predictor: per-branch history table (BHT)
// selecting a saturating counter in a shared pattern history table (PHT).
//
// state   | meaning
// --------+------------------------------------------------------------
// e_reset | held in reset; first cycle after release also clears entry 0
// e_clear | sweeping tables to init values, one entry per cycle
// e_ready | tables valid; predictions and updates accepted
module bp_fe_bp_two_level_cfg #(
    parameter int bht_idx_width_p   = 6,
    parameter int bp_n_hist         = 6,
    parameter int bp_cnt_sat_bits_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       taken_i,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic                       ready_o
);

    localparam int els_lp       = 2 ** bht_idx_width_p;
    localparam int pht_els_lp   = 2 ** bp_n_hist;
    localparam int sweep_els_lp = (els_lp > pht_els_lp) ? els_lp : pht_els_lp;
    localparam int sweep_w_lp   = $clog2(sweep_els_lp);

    localparam logic [sweep_w_lp-1:0]        sweep_last_lp = sweep_w_lp'(sweep_els_lp - 1);
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_init_lp   = bp_cnt_sat_bits_p'((2 ** (bp_cnt_sat_bits_p - 1)) - 1);
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_max_lp    = '1;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_clear = 2'd1,
        e_ready = 2'd2
    } state_e;

    state_e                  state_r, state_n;
    logic [sweep_w_lp-1:0]   sweep_cnt_r, sweep_cnt_n;
    logic                    clear_v;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_reset;
            sweep_cnt_r <= '0;
        end else begin
            state_r     <= state_n;
            sweep_cnt_r <= sweep_cnt_n;
        end
    end

    // e_reset is only visible with reset_i low for one cycle, which is
    // treated as the first sweep cycle so the sweep takes exactly N cycles.
    always_comb begin
        state_n     = state_r;
        sweep_cnt_n = sweep_cnt_r;
        clear_v     = 1'b0;
        ready_o     = 1'b0;
        case (state_r)
            e_reset, e_clear: begin
                clear_v = 1'b1;
                if (sweep_cnt_r == sweep_last_lp) begin
                    state_n     = e_ready;
                    sweep_cnt_n = '0;
                end else begin
                    state_n     = e_clear;
                    sweep_cnt_n = sweep_cnt_r + sweep_w_lp'(1);
                end
            end
            e_ready: ready_o = 1'b1;
            default: state_n = e_reset;
        endcase
    end

    logic                       bht_clr_v, pht_clr_v;
    logic [bht_idx_width_p-1:0] bht_clr_idx;
    logic [bp_n_hist-1:0]       pht_clr_idx;

    assign bht_clr_idx = sweep_cnt_r[bht_idx_width_p-1:0];
    assign pht_clr_idx = sweep_cnt_r[bp_n_hist-1:0];

    // The smaller table only takes the low part of the sweep.
    if (els_lp == sweep_els_lp) begin : g_bht_full
        assign bht_clr_v = clear_v;
    end else begin : g_bht_part
        assign bht_clr_v = clear_v & ~(|sweep_cnt_r[sweep_w_lp-1:bht_idx_width_p]);
    end

    if (pht_els_lp == sweep_els_lp) begin : g_pht_full
        assign pht_clr_v = clear_v;
    end else begin : g_pht_part
        assign pht_clr_v = clear_v & ~(|sweep_cnt_r[sweep_w_lp-1:bp_n_hist]);
    end

    logic [bp_n_hist-1:0]         bht_r [els_lp];
    logic [bp_cnt_sat_bits_p-1:0] pht_r [pht_els_lp];

    logic                         w_acc, r_acc;
    logic [bp_n_hist-1:0]         hist_w, hist_w_n;
    logic [bp_cnt_sat_bits_p-1:0] cnt_w, cnt_w_n;

    assign w_acc    = w_v_i & ready_o;
    assign r_acc    = r_v_i & ready_o;
    assign hist_w   = bht_r[idx_w_i];
    assign cnt_w    = pht_r[hist_w];
    assign hist_w_n = bp_n_hist'({hist_w, taken_i});

    always_comb begin
        cnt_w_n = cnt_w;
        if (taken_i && (cnt_w != cnt_max_lp))
            cnt_w_n = cnt_w + bp_cnt_sat_bits_p'(1);
        else if (!taken_i && (cnt_w != '0))
            cnt_w_n = cnt_w - bp_cnt_sat_bits_p'(1);
    end

    always_ff @(posedge clk_i) begin
        if (bht_clr_v)
            bht_r[bht_clr_idx] <= '0;
        else if (w_acc)
            bht_r[idx_w_i] <= hist_w_n;

        if (pht_clr_v)
            pht_r[pht_clr_idx] <= cnt_init_lp;
        else if (w_acc)
            pht_r[hist_w] <= cnt_w_n;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            predict_v_o <= 1'b0;
            predict_o   <= 1'b0;
        end else begin
            predict_v_o <= r_acc;
            if (r_acc)
                predict_o <= pht_r[bht_r[idx_r_i]][bp_cnt_sat_bits_p-1];
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_two_level_cfg.sv
// Self-checking bench for bp_fe_bp_two_level_cfg with 16 histories of 3 bits
// and 2-bit counters; directed scenarios followed by randomized traffic.
module tb_bp_fe_bp_two_level_cfg;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       w_v_i = 1'b0;
    logic [3:0] idx_w_i = '0;
    logic       taken_i = 1'b0;
    logic       r_v_i = 1'b0;
    logic [3:0] idx_r_i = '0;
    logic       predict_v_o, predict_o, ready_o;

    bp_fe_bp_two_level_cfg #(
        .bht_idx_width_p  (4),
        .bp_n_hist        (3),
        .bp_cnt_sat_bits_p(2)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .w_v_i      (w_v_i),
        .idx_w_i    (idx_w_i),
        .taken_i    (taken_i),
        .r_v_i      (r_v_i),
        .idx_r_i    (idx_r_i),
        .predict_v_o(predict_v_o),
        .predict_o  (predict_o),
        .ready_o    (ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: histories as integers 0..7, counters as integers 0..3.
    int bht_m [16];
    int pht_m [8];
    int since = 0;
    bit last_pred = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic init_model();
        for (int i = 0; i < 16; i++) bht_m[i] = 0;
        for (int i = 0; i < 8; i++) pht_m[i] = 1;
        last_pred = 1'b0;
        since = 0;
    endtask

    task automatic do_reset(input int cycles);
        reset_i = 1'b1;
        w_v_i = 1'b0;
        r_v_i = 1'b0;
        repeat (cycles) begin
            @(posedge clk_i);
            #1;
            check_val("rst_ready", ready_o, 0);
            check_val("rst_pred_v", predict_v_o, 0);
            check_val("rst_pred", predict_o, 0);
        end
        init_model();
        reset_i = 1'b0;
    endtask

    task automatic step(input bit r, input logic [3:0] ri, input bit w, input logic [3:0] wi, input bit t);
        bit rdy, exp_v;
        int h;
        rdy     = (since >= 16);
        r_v_i   = r;
        idx_r_i = ri;
        w_v_i   = w;
        idx_w_i = wi;
        taken_i = t;
        exp_v   = r && rdy;
        if (exp_v)
            last_pred = (pht_m[bht_m[ri]] >= 2);
        if (w && rdy) begin
            h = bht_m[wi];
            if (t) pht_m[h] = (pht_m[h] == 3) ? 3 : pht_m[h] + 1;
            else   pht_m[h] = (pht_m[h] == 0) ? 0 : pht_m[h] - 1;
            bht_m[wi] = (h * 2 + (t ? 1 : 0)) % 8;
        end
        @(posedge clk_i);
        #1;
        if (!reset_i && since < 1000) since++;
        check_val("ready", ready_o, (since >= 16) ? 1 : 0);
        check_val("pred_v", predict_v_o, exp_v);
        check_val("pred", predict_o, last_pred);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wait_ready(input string tag, input bit noisy);
        int n;
        n = 0;
        while (!ready_o && n < 40) begin
            n++;
            if (noisy) step(1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'($urandom));
            else idle();
        end
        check_val(tag, n, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        init_model();
        do_reset(3);

        // Requests during the sweep must be ignored and must not disturb init values.
        wait_ready("clear_len", 1'b1);

        step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        check_val("rd5_v", predict_v_o, 1);
        check_val("rd5", predict_o, 0);

        step(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        check_val("rd3_after_upd", predict_o, 0);
        step(1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        check_val("rd7_after_upd", predict_o, 1);

        repeat (6) step(1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
        step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        check_val("sat_hi", predict_o, 1);
        step(1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        check_val("after_nt", predict_o, 0);

        do_reset(2);
        wait_ready("clear_len2", 1'b0);
        step(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd3, 1'b1, 4'd3, 1'b1);
        check_val("same_cyc", predict_o, 0);
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        check_val("next_hist", predict_o, 0);
        idle();
        check_val("hold_v", predict_v_o, 0);

        do_reset(2);
        repeat (10) idle();
        check_val("mid_clear_rdy", ready_o, 0);
        do_reset(1);
        wait_ready("clear_restart", 1'b0);

        for (int c = 0; c < 500; c++) begin
            if (c == 250) begin
                do_reset(2);
            end
            step(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
